// File: rtl/string_filter_multi.sv
// string_filter_multi: streaming classifier for newline-separated lowercase strings.
// Each string is judged "nice" against a compile-time ruleset:
//   RULESET=1 : >=3 vowels, a doubled letter, none of ab/cd/pq/xy
//   RULESET=2 : a non-overlapping letter pair seen twice, and a letter-gap-letter repeat
// Optional feature macro: STRING_FILTER_MULTI_STATS_EN adds string_count and max_len.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inbound_valid/_data   ASCII byte stream (LF terminates, NUL ends input)
//   string_is_nice        1-cycle pulse, verdict of the string just terminated
//   string_done           1-cycle pulse on every evaluation (empty strings included)
//   nice_count            saturating count of nice strings
//   end_of_file           sticky, set the cycle after NUL is accepted
//   string_count, max_len (STATS_EN only) evaluations count, longest letter count
module string_filter_multi #(
  parameter int unsigned INBOUND_DATA_WIDTH = 8,
  parameter int unsigned RULESET            = 1,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inbound_valid,
  input  logic [INBOUND_DATA_WIDTH-1:0] inbound_data,
  output logic                          string_is_nice,
  output logic                          string_done,
  output logic [COUNT_WIDTH-1:0]        nice_count,
  output logic                          end_of_file
`ifdef STRING_FILTER_MULTI_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0]        string_count,
  output logic [7:0]                    max_len
`endif
);

  localparam int unsigned LETTER_W = 5;
  localparam int unsigned PAIR_W   = 10;
  localparam int unsigned NUM_PAIRS = 676;

  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_LF  = INBOUND_DATA_WIDTH'(8'h0A);
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_NUL = INBOUND_DATA_WIDTH'(8'h00);
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_A   = INBOUND_DATA_WIDTH'(8'h61);
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_Z   = INBOUND_DATA_WIDTH'(8'h7A);

  typedef enum logic {IN_STRING, DONE} state_t;

  state_t                state;
  logic [LETTER_W-1:0]   prev1;
  logic                  prev1_valid;
  logic                  char_seen;

  logic                  accept_c;
  logic                  is_letter_c;
  logic                  is_lf_c;
  logic                  is_nul_c;
  logic                  letter_stb_c;
  logic                  eval_stb_c;
  logic                  clear_stb_c;
  logic                  verdict_c;
  logic [LETTER_W-1:0]   cur_c;

  // Elaboration-time parameter checks
  if (INBOUND_DATA_WIDTH != 8) begin : g_bad_width
    $error("string_filter_multi: INBOUND_DATA_WIDTH must be 8");
  end

  // Byte classification; DONE ignores all input
  assign accept_c     = inbound_valid && (state == IN_STRING);
  assign is_letter_c  = (inbound_data >= CH_A) && (inbound_data <= CH_Z);
  assign is_lf_c      = (inbound_data == CH_LF);
  assign is_nul_c     = (inbound_data == CH_NUL);
  assign letter_stb_c = accept_c && is_letter_c;
  // NUL closes a pending string as if an LF had arrived
  assign eval_stb_c   = accept_c && (is_lf_c || (is_nul_c && char_seen));
  assign clear_stb_c  = accept_c && (is_lf_c || is_nul_c);
  assign cur_c        = LETTER_W'(inbound_data - CH_A);

  // FSM, shared per-string history and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IN_STRING;
      prev1          <= '0;
      prev1_valid    <= 1'b0;
      char_seen      <= 1'b0;
      string_is_nice <= 1'b0;
      string_done    <= 1'b0;
      nice_count     <= '0;
      end_of_file    <= 1'b0;
    end else begin
      string_done    <= 1'b0;
      string_is_nice <= 1'b0;
      if (eval_stb_c) begin
        string_done    <= 1'b1;
        string_is_nice <= verdict_c;
        if (verdict_c && (nice_count != '1)) begin
          nice_count <= nice_count + COUNT_WIDTH'(1);
        end
      end
      if (clear_stb_c) begin
        prev1       <= '0;
        prev1_valid <= 1'b0;
        char_seen   <= 1'b0;
      end else if (letter_stb_c) begin
        prev1       <= cur_c;
        prev1_valid <= 1'b1;
        char_seen   <= 1'b1;
      end
      case (state)
        IN_STRING: begin
          if (accept_c && is_nul_c) begin
            state       <= DONE;
            end_of_file <= 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IN_STRING;
      endcase
    end
  end

  if (RULESET == 1) begin : g_rs1
    logic [1:0] vowels;
    logic       has_double;
    logic       has_forbidden;
    logic       is_vowel_c;
    logic       forbid_c;

    assign is_vowel_c = cur_c inside {5'd0, 5'd4, 5'd8, 5'd14, 5'd20};
    // ab, cd, pq, xy are all "first letter then its successor"
    assign forbid_c   = prev1_valid && (cur_c == prev1 + 5'd1) &&
                        (prev1 inside {5'd0, 5'd2, 5'd15, 5'd23});
    assign verdict_c  = (vowels == 2'd3) && has_double && !has_forbidden;

    // Per-string ruleset 1 flags
    always_ff @(posedge clk) begin
      if (reset || clear_stb_c) begin
        vowels        <= 2'd0;
        has_double    <= 1'b0;
        has_forbidden <= 1'b0;
      end else if (letter_stb_c) begin
        if (is_vowel_c && (vowels != 2'd3)) vowels <= vowels + 2'd1;
        if (prev1_valid && (cur_c == prev1)) has_double <= 1'b1;
        if (forbid_c) has_forbidden <= 1'b1;
      end
    end
  end else if (RULESET == 2) begin : g_rs2
    logic [NUM_PAIRS-1:0] pair_seen;
    logic [LETTER_W-1:0]  prev2;
    logic                 prev2_valid;
    logic                 has_pair_twice;
    logic                 has_gap_repeat;
    logic [PAIR_W-1:0]    cur_pair_c;
    logic [PAIR_W-1:0]    prev_pair_c;

    assign cur_pair_c  = PAIR_W'(prev1) * PAIR_W'(26) + PAIR_W'(cur_c);
    assign prev_pair_c = PAIR_W'(prev2) * PAIR_W'(26) + PAIR_W'(prev1);
    assign verdict_c   = has_pair_twice && has_gap_repeat;

    // The pair ending at the previous letter is inserted only after the current
    // lookup, so a pair can never match the one overlapping it ("aaa").
    always_ff @(posedge clk) begin
      if (reset || clear_stb_c) begin
        pair_seen      <= '0;
        prev2          <= '0;
        prev2_valid    <= 1'b0;
        has_pair_twice <= 1'b0;
        has_gap_repeat <= 1'b0;
      end else if (letter_stb_c) begin
        if (prev1_valid && pair_seen[cur_pair_c]) has_pair_twice <= 1'b1;
        if (prev2_valid) pair_seen[prev_pair_c] <= 1'b1;
        if (prev2_valid && (cur_c == prev2)) has_gap_repeat <= 1'b1;
        prev2       <= prev1;
        prev2_valid <= prev1_valid;
      end
    end
  end else begin : g_bad_ruleset
    $error("string_filter_multi: RULESET must be 1 or 2");
    assign verdict_c = 1'b0;
  end

`ifdef STRING_FILTER_MULTI_STATS_EN
  logic [7:0] cur_len;

  // Evaluation count and longest-string letter count
  always_ff @(posedge clk) begin
    if (reset) begin
      string_count <= '0;
      max_len      <= 8'd0;
      cur_len      <= 8'd0;
    end else begin
      if (eval_stb_c) begin
        if (string_count != '1) string_count <= string_count + COUNT_WIDTH'(1);
        if (cur_len > max_len) max_len <= cur_len;
      end
      if (clear_stb_c) begin
        cur_len <= 8'd0;
      end else if (letter_stb_c && (cur_len != 8'hFF)) begin
        cur_len <= cur_len + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_string_filter_multi.sv
// Directed bench for string_filter_multi: one instance per ruleset on a shared stream.
module tb_string_filter_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        inbound_valid;
  logic [7:0]  inbound_data;

  logic        nice1, done1, eof1;
  logic [15:0] cnt1;
  logic        nice2, done2, eof2;
  logic [15:0] cnt2;
`ifdef STRING_FILTER_MULTI_STATS_EN
  logic [15:0] scnt1, scnt2;
  logic [7:0]  mlen1, mlen2;
`endif

  int checks = 0;
  int errors = 0;
  bit q1[$];
  bit q2[$];

  always #5 clk = ~clk;

  string_filter_multi #(.INBOUND_DATA_WIDTH(8), .RULESET(1), .COUNT_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .inbound_valid(inbound_valid), .inbound_data(inbound_data),
    .string_is_nice(nice1), .string_done(done1), .nice_count(cnt1), .end_of_file(eof1)
`ifdef STRING_FILTER_MULTI_STATS_EN
    , .string_count(scnt1), .max_len(mlen1)
`endif
  );

  string_filter_multi #(.INBOUND_DATA_WIDTH(8), .RULESET(2), .COUNT_WIDTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .inbound_valid(inbound_valid), .inbound_data(inbound_data),
    .string_is_nice(nice2), .string_done(done2), .nice_count(cnt2), .end_of_file(eof2)
`ifdef STRING_FILTER_MULTI_STATS_EN
    , .string_count(scnt2), .max_len(mlen2)
`endif
  );

  // Record every verdict pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (done1) q1.push_back(nice1);
    if (done2) q2.push_back(nice2);
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare recorded pulse sequence of one instance against a string of '0'/'1'
  task automatic check_q(input string tag, input int which, input string exp);
    logic [31:0] ob;
    logic [31:0] eb;
    int n;
    ob = '0;
    eb = '0;
    n = (which == 1) ? q1.size() : q2.size();
    for (int i = 0; i < n && i < 32; i++) ob[i] = (which == 1) ? q1[i] : q2[i];
    for (int i = 0; i < exp.len() && i < 32; i++) eb[i] = (exp[i] == 8'h31);
    check({tag, "_pulses"}, 32'(n), 32'(exp.len()));
    check({tag, "_verdicts"}, ob, eb);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    inbound_valid = 1'b1;
    inbound_data  = b;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      inbound_valid = 1'b0;
      inbound_data  = 8'h55;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inbound_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    inbound_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  initial begin
    reset = 1'b1;
    inbound_valid = 1'b0;
    inbound_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_nice1", 32'(nice1), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_eof1", 32'(eof1), 32'd0);
    check("rst_cnt2", 32'(cnt2), 32'd0);
    check("rst_eof2", 32'(eof2), 32'd0);

    // Ruleset 1 main vectors, back-to-back, then NUL with no pending string
    apply_reset();
    send_str("ugknbfddgicrmopn\naaa\njchzalrnumimnmhp\nhaegwjzuvuyypxyu\ndvszwmarrgswjxmb\n", 0);
    send_byte(8'h00, 0);
    check("rs1_eof_before", 32'(eof1), 32'd0);
    idle(1);
    check("rs1_eof_after", 32'(eof1), 32'd1);
    check("rs1_nul_no_pulse", 32'(done1), 32'd0);
    idle(2);
    check_q("rs1_main", 1, "11000");
    check("rs1_count", 32'(cnt1), 32'd2);
    check("rs1_eof_sticky", 32'(eof1), 32'd1);

    // Ruleset 2 main vectors and overlap cases
    apply_reset();
    send_str("qjhvhtzxzqqjkmpb\nxxyxx\nuurcxstgmygtbstg\nieodomkazucvgmuy\n", 0);
    idle(2);
    check_q("rs2_main", 2, "1100");
    check("rs2_count", 32'(cnt2), 32'd2);
    send_str("aaa\naaaa\nabcab\n", 0);
    idle(2);
    check_q("rs2_overlap", 2, "1100010");
    check("rs2_count_overlap", 32'(cnt2), 32'd3);

    // Empty strings
    apply_reset();
    send_str("\n\n", 0);
    idle(2);
    check_q("empty_rs1", 1, "00");
    check_q("empty_rs2", 2, "00");
    check("empty_cnt1", 32'(cnt1), 32'd0);
    check("empty_cnt2", 32'(cnt2), 32'd0);

    // NUL as implicit terminator, later bytes ignored
    apply_reset();
    send_str("ugknbfddgicrmopn", 0);
    send_byte(8'h00, 0);
    idle(1);
    check("nul_term_done", 32'(done1), 32'd1);
    check("nul_term_nice", 32'(nice1), 32'd1);
    check("nul_term_eof", 32'(eof1), 32'd1);
    check("nul_term_cnt", 32'(cnt1), 32'd1);
    send_str("aaa\n", 0);
    idle(2);
    check_q("after_eof", 1, "1");
    check("after_eof_cnt", 32'(cnt1), 32'd1);

    // Reset mid-string discards the partial "aei" ("aeibbd" would be nice)
    apply_reset();
    send_str("aaa\n", 0);
    idle(2);
    check("pre_reset_cnt", 32'(cnt1), 32'd1);
    send_str("aei", 0);
    @(negedge clk);
    reset = 1'b1;
    inbound_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cnt", 32'(cnt1), 32'd0);
    check("midrst_no_pulse", 32'(q1.size()), 32'd1);
    send_str("bbd\n", 0);
    idle(2);
    check_q("midrst", 1, "10");
    check("midrst_cnt_after", 32'(cnt1), 32'd0);

    // Idle gaps and uppercase bytes between letters change nothing
    apply_reset();
    send_str("ugKknbfdXdgicrMmopn\n", 2);
    idle(2);
    check_q("gaps_upper", 1, "1");
    check("gaps_upper_cnt", 32'(cnt1), 32'd1);

`ifdef STRING_FILTER_MULTI_STATS_EN
    apply_reset();
    send_str("ab\nabcde\n\n", 0);
    idle(2);
    check("stats_string_count", 32'(scnt1), 32'd3);
    check("stats_max_len", 32'(mlen1), 32'd5);
    check("stats_string_count2", 32'(scnt2), 32'd3);
    check("stats_max_len2", 32'(mlen2), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
